saturn_bus_sequencer: RTL and testbench
=======================================

# saturn_bus_sequencer

Sequencer and arbiter that sits between the Saturn core and `hp48_bus`. It shares the single nibble bus between three requesters: instruction fetch, multi-nibble data-pointer transfers, and configure/reset commands. It generates every `bus_command`/`bus_strobe` pair, so the core's decoder no longer hand-sequences LOAD/READ phases.

## Interface
Parameters:
- `LEN_W`, default 4: width of transfer length field. A transfer moves `dp_len+1` nibbles, so 1..16 nibbles.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-low
- `fetch_req`  in  1  level; request one instruction nibble
- `fetch_jump`  in  1  with `fetch_req`; reload bus PC from `fetch_addr` first
- `fetch_addr`  in  20  new PC, used only when `fetch_jump`=1
- `fetch_valid`  out  1  one-cycle pulse; `fetch_nibble` valid
- `fetch_nibble`  out  4  fetched nibble
- `dp_req`  in  1  level; request a data transfer
- `dp_write`  in  1  1 = write, 0 = read
- `dp_addr`  in  20  start address
- `dp_len`  in  LEN_W  nibble count minus 1
- `dp_wdata`  in  4  current write nibble
- `dp_wnext`  out  1  pulse; requester advances `dp_wdata`
- `dp_rvalid`  out  1  pulse; `dp_rdata` valid
- `dp_rdata`  out  4  read nibble
- `dp_done`  out  1  pulse on final nibble of transfer
- `cfg_req`  in  1  level; configure or bus reset
- `cfg_reset`  in  1  1 = BUSCMD_RESET, 0 = BUSCMD_CONFIGURE
- `cfg_addr`  in  20  configure address
- `cfg_done`  out  1  pulse on completion
- `bus_command`  out  4  BUSCMD_* code
- `bus_address`  out  20  address for LOAD_PC/LOAD_DP/CONFIGURE
- `bus_nibble_in`  out  4  write nibble to bus
- `bus_nibble_out`  in  4  read nibble from bus
- `bus_strobe`  out  1  one-cycle command strobe
- `bus_error`  in  1  bus error, sampled in capture cycle
- `busy`  out  1  state ≠ IDLE
- `error`  out  1  sticky bus error

## Operation
- States: IDLE, LOAD, LOAD_CAP, XFER, XFER_CAP, ERROR.
- Each bus operation takes two cycles.
  - In the issue state, `bus_strobe`=1 and command, address and nibble are driven.
  - In the capture state, `bus_strobe`=0, `bus_nibble_out` and `bus_error` are sampled, and output pulses fire.
- IDLE arbitration:
  - `cfg_req` has highest priority.
  - Between `dp_req` and `fetch_req`, use round-robin on last grant.
  - After reset the last grant is fetch, so dp wins the first tie.
- Request fields are latched at grant. Requests are level-held until the matching done/valid pulse. Deasserting a request mid-operation does not abort it.
- Fetch:
  - If `fetch_jump`=1: LOAD(LOAD_PC, `fetch_addr`) → LOAD_CAP → XFER(PC_READ) → XFER_CAP.
  - Otherwise: XFER(PC_READ) → XFER_CAP.
  - The bus auto-increments its PC pointer. The sequencer never reloads PC except on `fetch_jump`.
- Data transfer:
  - LOAD(LOAD_DP, `dp_addr`) → LOAD_CAP, then `dp_len+1` iterations of XFER(DP_READ or DP_WRITE) → XFER_CAP.
  - Nibble counter `cnt` (LEN_W bits) clears at grant and increments in each XFER_CAP.
  - The last iteration is when `cnt`==`dp_len`. It pulses `dp_done` together with the final `dp_rvalid`/`dp_wnext`, then goes to IDLE.
  - Reads: `dp_rvalid` pulses in each XFER_CAP.
  - Writes: `bus_nibble_in`=`dp_wdata` during XFER; `dp_wnext` pulses in each XFER_CAP.
- Config: LOAD(CONFIGURE with `cfg_addr`, or RESET) → LOAD_CAP. `cfg_done` pulses in LOAD_CAP, then IDLE.
- Error handling:
  - `bus_error`=1 in any capture state → ERROR.
  - In ERROR, `error`=1, and no done/valid pulse is issued for that operation.
  - ERROR is held until reset.
- Outside issue states, `bus_command`=BUSCMD_NOP.

## Timing
- Reset values (on the edge where `reset`=0):
  - state IDLE; `bus_command`=NOP; `bus_strobe`=0; `bus_address`=0; `bus_nibble_in`=0.
  - all pulses 0; `fetch_nibble`=0; `dp_rdata`=0; `busy`=0; `error`=0; `cnt`=0.
- Reset mid-operation abandons the transfer silently; no done pulse is issued.
- Sequential fetch: request seen in IDLE at edge N → strobe in cycle N+1 → `fetch_valid` in N+2 → IDLE in N+3. Throughput is one nibble per 3 cycles.
- Jump fetch adds 2 cycles.
- Data transfer of k nibbles: 1 (IDLE) + 2 (load) + 2k cycles; `dp_done` fires in the last cycle.
- Requests arriving while busy wait. Simultaneous requests are resolved only in IDLE.

## Structure
- BUSCMD_* codes come from the shared `bus_commands.v` include.
- Sequencer state codes go in a new shared include `bus_seq_states.v`.
- One natural sub-module: `bus_rr_arbiter`, a 3-input fixed-plus-round-robin grant with a last-grant register.

## Test plan
- Reset, then `fetch_req`+`fetch_jump`, `fetch_addr`=0x00100 → LOAD_PC 0x00100 strobe, PC_READ strobe, `fetch_valid` with the bus nibble 4 cycles after grant.
- Read, `dp_addr`=0x80000, `dp_len`=4 → one LOAD_DP plus 5 DP_READ strobes; 5 `dp_rvalid` pulses; `dp_done` coincident with the 5th; 13 cycles total.
- Write, `dp_len`=0, `dp_wdata`=0xA → one DP_WRITE with `bus_nibble_in`=0xA; `dp_wnext` and `dp_done` in the same cycle.
- `fetch_req`, `dp_req` and `cfg_req` asserted together → grant order cfg, dp, fetch; a second dp/fetch tie goes to fetch.
- `bus_error` during the 3rd read nibble → ERROR, `error`=1, no `dp_done`, no further strobes. Reset clears it.
- Reset asserted mid-transfer → next cycle: all outputs at reset values, state IDLE.

Source files
------------

// File: rtl/saturn_bus_sequencer_pkg.sv
// Shared definitions for the Saturn bus sequencer: hp48_bus command codes,
// sequencer state codes and the requester identifiers.
package saturn_bus_sequencer_pkg;

    localparam logic [3:0] BUSCMD_NOP         = 4'h0;
    localparam logic [3:0] BUSCMD_ID          = 4'h1;
    localparam logic [3:0] BUSCMD_PC_READ     = 4'h2;
    localparam logic [3:0] BUSCMD_DP_READ     = 4'h3;
    localparam logic [3:0] BUSCMD_DP_WRITE    = 4'h4;
    localparam logic [3:0] BUSCMD_CONFIGURE   = 4'h5;
    localparam logic [3:0] BUSCMD_UNCONFIGURE = 4'h6;
    localparam logic [3:0] BUSCMD_RESET       = 4'h7;
    localparam logic [3:0] BUSCMD_LOAD_PC     = 4'h8;
    localparam logic [3:0] BUSCMD_LOAD_DP     = 4'h9;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_LOAD_CAP = 3'd2,
        ST_XFER     = 3'd3,
        ST_XFER_CAP = 3'd4,
        ST_ERROR    = 3'd5
    } seq_state_t;

    typedef enum logic [1:0] {
        OP_FETCH = 2'd0,
        OP_DP    = 2'd1,
        OP_CFG   = 2'd2
    } seq_op_t;

    // Nibble-transfer command for the operation currently owning the bus
    function automatic logic [3:0] xfer_cmd(input seq_op_t op, input logic write);
        logic [3:0] cmd;
        if (op == OP_DP) begin
            cmd = write ? BUSCMD_DP_WRITE : BUSCMD_DP_READ;
        end else begin
            cmd = BUSCMD_PC_READ;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/saturn_bus_sequencer_rr_arbiter.sv
// bus_rr_arbiter: configure requests always win; data-pointer and fetch
// requests alternate on a tie, remembering which of the two was served last.
module bus_rr_arbiter
    import saturn_bus_sequencer_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic cfg_req,
    input  logic dp_req,
    input  logic fetch_req,
    input  logic accept,
    output logic grant_cfg,
    output logic grant_dp,
    output logic grant_fetch
);

    logic last_dp_r;

    // One-hot grant: fixed priority for cfg, round-robin between dp and fetch
    always_comb begin
        grant_cfg   = 1'b0;
        grant_dp    = 1'b0;
        grant_fetch = 1'b0;
        if (cfg_req) begin
            grant_cfg = 1'b1;
        end else if (dp_req && fetch_req) begin
            if (last_dp_r) begin
                grant_fetch = 1'b1;
            end else begin
                grant_dp = 1'b1;
            end
        end else if (dp_req) begin
            grant_dp = 1'b1;
        end else if (fetch_req) begin
            grant_fetch = 1'b1;
        end else begin
            grant_cfg = 1'b0;
        end
    end

    // Last-grant register; starts as "fetch" so dp wins the first tie
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_dp_r <= 1'b0;
        end else if (accept && grant_dp) begin
            last_dp_r <= 1'b1;
        end else if (accept && grant_fetch) begin
            last_dp_r <= 1'b0;
        end else begin
            last_dp_r <= last_dp_r;
        end
    end

endmodule

// File: rtl/saturn_bus_sequencer.sv
// saturn_bus_sequencer: shares the hp48 nibble bus between instruction fetch,
// data-pointer transfers and configure/reset, issuing every command/strobe pair.
module saturn_bus_sequencer
    import saturn_bus_sequencer_pkg::*;
#(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch_req,
    input  logic             fetch_jump,
    input  logic [19:0]      fetch_addr,
    output logic             fetch_valid,
    output logic [3:0]       fetch_nibble,
    input  logic             dp_req,
    input  logic             dp_write,
    input  logic [19:0]      dp_addr,
    input  logic [LEN_W-1:0] dp_len,
    input  logic [3:0]       dp_wdata,
    output logic             dp_wnext,
    output logic             dp_rvalid,
    output logic [3:0]       dp_rdata,
    output logic             dp_done,
    input  logic             cfg_req,
    input  logic             cfg_reset,
    input  logic [19:0]      cfg_addr,
    output logic             cfg_done,
    output logic [3:0]       bus_command,
    output logic [19:0]      bus_address,
    output logic [3:0]       bus_nibble_in,
    input  logic [3:0]       bus_nibble_out,
    output logic             bus_strobe,
    input  logic             bus_error,
    output logic             busy,
    output logic             error
);

    seq_state_t       state_r;
    seq_op_t          op_r;
    logic             write_r;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] cnt_r;
    logic             idle_s;
    logic             grant_cfg_s;
    logic             grant_dp_s;
    logic             grant_fetch_s;
    logic             xfer_ok_s;
    logic             last_s;

    assign idle_s = (state_r == ST_IDLE);

    bus_rr_arbiter u_arb (
        .clk         (clk),
        .reset       (reset),
        .cfg_req     (cfg_req),
        .dp_req      (dp_req),
        .fetch_req   (fetch_req),
        .accept      (idle_s),
        .grant_cfg   (grant_cfg_s),
        .grant_dp    (grant_dp_s),
        .grant_fetch (grant_fetch_s)
    );

    // Sequencer FSM; bus-side command, address and strobe are registered and
    // carry a real command only in the cycle following entry to an issue state
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            op_r        <= OP_FETCH;
            write_r     <= 1'b0;
            len_r       <= {LEN_W{1'b0}};
            cnt_r       <= {LEN_W{1'b0}};
            bus_command <= BUSCMD_NOP;
            bus_address <= 20'h00000;
            bus_strobe  <= 1'b0;
        end else begin
            bus_command <= BUSCMD_NOP;
            bus_address <= 20'h00000;
            bus_strobe  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_cfg_s) begin
                        op_r       <= OP_CFG;
                        cnt_r      <= {LEN_W{1'b0}};
                        state_r    <= ST_LOAD;
                        bus_strobe <= 1'b1;
                        if (cfg_reset) begin
                            bus_command <= BUSCMD_RESET;
                        end else begin
                            bus_command <= BUSCMD_CONFIGURE;
                            bus_address <= cfg_addr;
                        end
                    end else if (grant_dp_s) begin
                        op_r        <= OP_DP;
                        write_r     <= dp_write;
                        len_r       <= dp_len;
                        cnt_r       <= {LEN_W{1'b0}};
                        state_r     <= ST_LOAD;
                        bus_strobe  <= 1'b1;
                        bus_command <= BUSCMD_LOAD_DP;
                        bus_address <= dp_addr;
                    end else if (grant_fetch_s) begin
                        op_r       <= OP_FETCH;
                        cnt_r      <= {LEN_W{1'b0}};
                        bus_strobe <= 1'b1;
                        if (fetch_jump) begin
                            state_r     <= ST_LOAD;
                            bus_command <= BUSCMD_LOAD_PC;
                            bus_address <= fetch_addr;
                        end else begin
                            state_r     <= ST_XFER;
                            bus_command <= BUSCMD_PC_READ;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    state_r <= ST_LOAD_CAP;
                end
                ST_LOAD_CAP: begin
                    if (bus_error) begin
                        state_r <= ST_ERROR;
                    end else if (op_r == OP_CFG) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r     <= ST_XFER;
                        bus_strobe  <= 1'b1;
                        bus_command <= xfer_cmd(op_r, write_r);
                    end
                end
                ST_XFER: begin
                    state_r <= ST_XFER_CAP;
                end
                ST_XFER_CAP: begin
                    cnt_r <= cnt_r + {{(LEN_W-1){1'b0}}, 1'b1};
                    if (bus_error) begin
                        state_r <= ST_ERROR;
                    end else if (op_r != OP_DP || last_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r     <= ST_XFER;
                        bus_strobe  <= 1'b1;
                        bus_command <= xfer_cmd(op_r, write_r);
                    end
                end
                ST_ERROR: begin
                    state_r <= ST_ERROR;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Capture-cycle pulses: a bus error in the same cycle suppresses them,
    // so the bus nibble is forwarded while it is still on the wire
    always_comb begin
        xfer_ok_s   = (state_r == ST_XFER_CAP) && !bus_error;
        last_s      = (cnt_r == len_r);
        fetch_valid = xfer_ok_s && (op_r == OP_FETCH);
        dp_rvalid   = xfer_ok_s && (op_r == OP_DP) && !write_r;
        dp_wnext    = xfer_ok_s && (op_r == OP_DP) && write_r;
        dp_done     = xfer_ok_s && (op_r == OP_DP) && last_s;
        cfg_done    = (state_r == ST_LOAD_CAP) && !bus_error && (op_r == OP_CFG);
        busy        = !idle_s;
        error       = (state_r == ST_ERROR);
        if (fetch_valid) begin
            fetch_nibble = bus_nibble_out;
        end else begin
            fetch_nibble = 4'h0;
        end
        if (dp_rvalid) begin
            dp_rdata = bus_nibble_out;
        end else begin
            dp_rdata = 4'h0;
        end
        // Live write data so a dp_wnext advance shows up in the next XFER
        if ((state_r == ST_XFER) && (op_r == OP_DP) && write_r) begin
            bus_nibble_in = dp_wdata;
        end else begin
            bus_nibble_in = 4'h0;
        end
    end

endmodule

// File: tb/tb_saturn_bus_sequencer.sv
// Self-checking bench for saturn_bus_sequencer: a bus model feeds read nibbles,
// a scoreboard holds expected strobes and read data, a table drives transactions.
module tb_saturn_bus_sequencer;
    import saturn_bus_sequencer_pkg::*;

    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             fetch_req, fetch_jump;
    logic [19:0]      fetch_addr;
    logic             fetch_valid;
    logic [3:0]       fetch_nibble;
    logic             dp_req, dp_write;
    logic [19:0]      dp_addr;
    logic [LEN_W-1:0] dp_len;
    logic [3:0]       dp_wdata;
    logic             dp_wnext, dp_rvalid, dp_done;
    logic [3:0]       dp_rdata;
    logic             cfg_req, cfg_reset, cfg_done;
    logic [19:0]      cfg_addr;
    logic [3:0]       bus_command;
    logic [19:0]      bus_address;
    logic [3:0]       bus_nibble_in, bus_nibble_out;
    logic             bus_strobe, bus_error, busy, error;

    typedef struct {
        logic [3:0]  cmd;
        logic [19:0] addr;
        logic [3:0]  nib;
    } strb_t;

    typedef struct {
        int          kind;    // 0 fetch, 1 data transfer, 2 configure/reset
        logic        jump;
        logic        write;
        logic        rst;
        logic [19:0] addr;
        logic [3:0]  len;
        logic [3:0]  wdata;
        int          cycles;  // total cycles including the granting IDLE cycle
    } txn_t;

    strb_t      exp_q[$];
    logic [3:0] rd_q[$];
    txn_t       tbl[8];
    int n_cmp = 0, n_fail = 0;
    int n_fv = 0, n_rv = 0, n_wn = 0, n_dd = 0, n_cd = 0;
    int rd_idx = 0, err_at = -1;

    saturn_bus_sequencer #(.LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_jump(fetch_jump), .fetch_addr(fetch_addr),
        .fetch_valid(fetch_valid), .fetch_nibble(fetch_nibble),
        .dp_req(dp_req), .dp_write(dp_write), .dp_addr(dp_addr), .dp_len(dp_len),
        .dp_wdata(dp_wdata), .dp_wnext(dp_wnext), .dp_rvalid(dp_rvalid),
        .dp_rdata(dp_rdata), .dp_done(dp_done),
        .cfg_req(cfg_req), .cfg_reset(cfg_reset), .cfg_addr(cfg_addr), .cfg_done(cfg_done),
        .bus_command(bus_command), .bus_address(bus_address),
        .bus_nibble_in(bus_nibble_in), .bus_nibble_out(bus_nibble_out),
        .bus_strobe(bus_strobe), .bus_error(bus_error), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [3:0] c, input logic [19:0] a, input logic [3:0] n);
        strb_t e;
        e.cmd = c; e.addr = a; e.nib = n;
        exp_q.push_back(e);
    endtask

    task automatic pop_rd(input string name, input logic [3:0] act);
        if (rd_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL %s: got unexpected data pulse %0h, required none", name, act);
        end else begin
            check(name, 32'(act), 32'(rd_q.pop_front()));
        end
    endtask

    // One clock: at the falling edge check the bus side and act as the bus
    task automatic tick();
        strb_t      e;
        logic [3:0] nib;
        @(negedge clk);
        if (bus_strobe === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_strobe: got cmd %0h addr %05h, required no strobe",
                         bus_command, bus_address);
            end else begin
                e = exp_q.pop_front();
                check("strobe_cmd", 32'(bus_command), 32'(e.cmd));
                check("strobe_addr", 32'(bus_address), 32'(e.addr));
                check("strobe_nibble_in", 32'(bus_nibble_in), 32'(e.nib));
            end
            bus_error = 1'b0;
            if (bus_command == BUSCMD_PC_READ || bus_command == BUSCMD_DP_READ) begin
                rd_idx++;
                nib = 4'($urandom_range(0, 15));
                bus_nibble_out = nib;
                if (rd_idx == err_at) bus_error = 1'b1;
                else rd_q.push_back(nib);
            end
        end else begin
            check("nop_outside_issue", 32'(bus_command), 32'(BUSCMD_NOP));
        end
        if (fetch_valid === 1'b1) begin n_fv++; pop_rd("fetch_nibble", fetch_nibble); end
        if (dp_rvalid === 1'b1)   begin n_rv++; pop_rd("dp_rdata", dp_rdata); end
        if (dp_wnext === 1'b1)    begin n_wn++; dp_wdata = dp_wdata + 4'd1; end
        if (dp_done === 1'b1)     n_dd++;
        if (cfg_done === 1'b1)    n_cd++;
    endtask

    task automatic wait_for(input int sel, input int budget, output int cyc);
        logic hit;
        cyc = 0;
        hit = 1'b0;
        while (!hit && cyc < budget) begin
            tick();
            cyc++;
            case (sel)
                0: hit = fetch_valid;
                1: hit = dp_done;
                2: hit = cfg_done;
                default: hit = error;
            endcase
        end
        if (!hit) begin
            n_cmp++; n_fail++;
            $display("FAIL wait_timeout: event %0d absent after %0d cycles, required pulse", sel, budget);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_bus_command", 32'(bus_command), 32'(BUSCMD_NOP));
        check("rst_bus_strobe", 32'(bus_strobe), 32'd0);
        check("rst_bus_address", 32'(bus_address), 32'd0);
        check("rst_bus_nibble_in", 32'(bus_nibble_in), 32'd0);
        check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        check("rst_fetch_nibble", 32'(fetch_nibble), 32'd0);
        check("rst_dp_rvalid", 32'(dp_rvalid), 32'd0);
        check("rst_dp_rdata", 32'(dp_rdata), 32'd0);
        check("rst_dp_wnext", 32'(dp_wnext), 32'd0);
        check("rst_dp_done", 32'(dp_done), 32'd0);
        check("rst_cfg_done", 32'(cfg_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_error", 32'(error), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        fetch_req = 1'b0; dp_req = 1'b0; cfg_req = 1'b0; fetch_jump = 1'b0;
        bus_error = 1'b0;
        tick();
        exp_q.delete();
        rd_q.delete();
        reset = 1'b1;
    endtask

    task automatic run_txn(input txn_t t);
        int cyc, rv0, wn0;
        rv0 = n_rv;
        wn0 = n_wn;
        case (t.kind)
            0: begin
                if (t.jump) push(BUSCMD_LOAD_PC, t.addr, 4'h0);
                push(BUSCMD_PC_READ, 20'h00000, 4'h0);
                fetch_jump = t.jump; fetch_addr = t.addr; fetch_req = 1'b1;
            end
            1: begin
                push(BUSCMD_LOAD_DP, t.addr, 4'h0);
                for (int i = 0; i <= int'(t.len); i++)
                    push(t.write ? BUSCMD_DP_WRITE : BUSCMD_DP_READ, 20'h00000,
                         t.write ? 4'(t.wdata + 4'(i)) : 4'h0);
                dp_write = t.write; dp_addr = t.addr; dp_len = t.len;
                dp_wdata = t.wdata; dp_req = 1'b1;
            end
            default: begin
                push(t.rst ? BUSCMD_RESET : BUSCMD_CONFIGURE, t.rst ? 20'h00000 : t.addr, 4'h0);
                cfg_reset = t.rst; cfg_addr = t.addr; cfg_req = 1'b1;
            end
        endcase
        wait_for(t.kind, 80, cyc);
        check("txn_cycles", 32'(cyc + 1), 32'(t.cycles));
        if (t.kind == 1) begin
            check("done_with_last_nibble", 32'(t.write ? dp_wnext : dp_rvalid), 32'd1);
            check("nibble_pulses", 32'(t.write ? n_wn - wn0 : n_rv - rv0), 32'(int'(t.len) + 1));
        end
        fetch_req = 1'b0; dp_req = 1'b0; cfg_req = 1'b0; fetch_jump = 1'b0;
        tick();
        check("busy_after_txn", 32'(busy), 32'd0);
        check("strobes_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int cyc, rv0, dd0;
        tbl[0] = '{0, 1'b1, 1'b0, 1'b0, 20'h00100, 4'h0, 4'h0, 5};
        tbl[1] = '{0, 1'b0, 1'b0, 1'b0, 20'h00000, 4'h0, 4'h0, 3};
        tbl[2] = '{1, 1'b0, 1'b0, 1'b0, 20'h80000, 4'h4, 4'h0, 13};
        tbl[3] = '{1, 1'b0, 1'b1, 1'b0, 20'h12345, 4'h0, 4'hA, 5};
        tbl[4] = '{1, 1'b0, 1'b1, 1'b0, 20'h0ABCD, 4'h2, 4'h3, 9};
        tbl[5] = '{2, 1'b0, 1'b0, 1'b0, 20'h70000, 4'h0, 4'h0, 3};
        tbl[6] = '{2, 1'b0, 1'b0, 1'b1, 20'h99999, 4'h0, 4'h0, 3};
        tbl[7] = '{1, 1'b0, 1'b0, 1'b0, 20'hFFFFF, 4'hF, 4'h0, 35};

        reset = 1'b0;
        fetch_req = 1'b0; fetch_jump = 1'b0; fetch_addr = 20'h00000;
        dp_req = 1'b0; dp_write = 1'b0; dp_addr = 20'h00000; dp_len = 4'h0; dp_wdata = 4'h0;
        cfg_req = 1'b0; cfg_reset = 1'b0; cfg_addr = 20'h00000;
        bus_nibble_out = 4'h0; bus_error = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals();
        reset = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) run_txn(tbl[i]);

        // All three requesters at once: cfg, then dp, then fetch on the re-tie
        do_reset();
        push(BUSCMD_CONFIGURE, 20'h11111, 4'h0);
        push(BUSCMD_LOAD_DP, 20'h22222, 4'h0);
        push(BUSCMD_DP_READ, 20'h00000, 4'h0);
        push(BUSCMD_DP_READ, 20'h00000, 4'h0);
        push(BUSCMD_PC_READ, 20'h00000, 4'h0);
        push(BUSCMD_LOAD_DP, 20'h22222, 4'h0);
        push(BUSCMD_DP_READ, 20'h00000, 4'h0);
        push(BUSCMD_DP_READ, 20'h00000, 4'h0);
        cfg_reset = 1'b0; cfg_addr = 20'h11111; cfg_req = 1'b1;
        dp_write = 1'b0; dp_addr = 20'h22222; dp_len = 4'h1; dp_req = 1'b1;
        fetch_jump = 1'b0; fetch_req = 1'b1;
        wait_for(2, 20, cyc);
        check("arb_cfg_first_cycles", 32'(cyc), 32'd2);
        cfg_req = 1'b0;
        wait_for(1, 20, cyc);
        check("arb_dp_second_cycles", 32'(cyc), 32'd7);
        wait_for(0, 20, cyc);
        check("arb_fetch_wins_retie_cycles", 32'(cyc), 32'd3);
        fetch_req = 1'b0;
        wait_for(1, 20, cyc);
        check("arb_dp_again_cycles", 32'(cyc), 32'd7);
        dp_req = 1'b0;
        tick();
        check("arb_strobes_left", 32'(exp_q.size()), 32'd0);
        check("arb_busy_after", 32'(busy), 32'd0);

        // Bus error on the third read nibble
        do_reset();
        err_at = rd_idx + 3;
        rv0 = n_rv;
        dd0 = n_dd;
        push(BUSCMD_LOAD_DP, 20'h80000, 4'h0);
        repeat (3) push(BUSCMD_DP_READ, 20'h00000, 4'h0);
        dp_write = 1'b0; dp_addr = 20'h80000; dp_len = 4'h4; dp_req = 1'b1;
        wait_for(3, 30, cyc);
        check("err_entry_cycles", 32'(cyc), 32'd9);
        check("err_flag", 32'(error), 32'd1);
        check("err_busy", 32'(busy), 32'd1);
        check("err_rvalid_count", 32'(n_rv - rv0), 32'd2);
        dp_req = 1'b0;
        repeat (8) tick();
        check("err_sticky", 32'(error), 32'd1);
        check("err_no_done", 32'(n_dd - dd0), 32'd0);
        check("err_no_more_strobes", 32'(exp_q.size()), 32'd0);
        err_at = -1;
        do_reset();
        check("err_cleared", 32'(error), 32'd0);
        check("err_idle_after_reset", 32'(busy), 32'd0);

        // Reset in the middle of an 8-nibble write
        dd0 = n_dd;
        push(BUSCMD_LOAD_DP, 20'h54321, 4'h0);
        for (int i = 0; i < 8; i++) push(BUSCMD_DP_WRITE, 20'h00000, 4'(4'h5 + 4'(i)));
        dp_write = 1'b1; dp_addr = 20'h54321; dp_len = 4'h7; dp_wdata = 4'h5; dp_req = 1'b1;
        repeat (6) tick();
        check("mid_busy_before_reset", 32'(busy), 32'd1);
        do_reset();
        check_reset_vals();
        check("mid_no_done", 32'(n_dd - dd0), 32'd0);
        run_txn(tbl[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
